// File: rtl/bus_buffers.sv
// CPU address/data buffers plus the external memory transaction sequencer.
// Wait states raise stall; a watchdog aborts transactions that never complete.
module bus_buffers #(
    parameter int         WAIT_LIMIT = 15,
    parameter logic [7:0] HIGH_PAGE  = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr_in,
    input  logic [7:0]  data_in,
    input  logic        addr_buf_load,
    input  logic        addr_ff00_sel,
    input  logic        data_buf_load,
    input  logic        data_buf_write,
    input  logic        addr_buf_write_ext,
    input  logic        data_buf_load_ext,
    input  logic        data_buf_write_ext,
    output logic [7:0]  data_out,
    output logic        data_out_en,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR} state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t      state, state_next;
    logic [15:0] abuf, abuf_next;
    logic [7:0]  dbuf, dbuf_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic        err_next;
    logic        read_cmd, write_cmd;

    assign read_cmd  = addr_buf_write_ext & data_buf_load_ext;
    assign write_cmd = addr_buf_write_ext & data_buf_write_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            abuf      <= '0;
            dbuf      <= '0;
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            state     <= state_next;
            abuf      <= abuf_next;
            dbuf      <= dbuf_next;
            wait_cnt  <= wait_cnt_next;
            bus_error <= err_next;
        end
    end

    // A conflicting read+write command runs as a read and flags an error.
    always_comb begin
        state_next    = state;
        abuf_next     = abuf;
        dbuf_next     = dbuf;
        wait_cnt_next = wait_cnt;
        err_next      = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        stall         = 1'b0;
        case (state)
            IDLE: begin
                if (addr_buf_load)
                    abuf_next = addr_ff00_sel ? {HIGH_PAGE, addr_in[7:0]} : addr_in;
                if (data_buf_load)
                    dbuf_next = data_in;
                if (read_cmd) begin
                    mem_rd   = 1'b1;
                    err_next = write_cmd;
                    if (mem_ready) begin
                        dbuf_next = mem_rdata;
                    end else begin
                        stall         = 1'b1;
                        state_next    = WAIT_RD;
                        wait_cnt_next = 8'd1;
                    end
                end else if (write_cmd) begin
                    mem_wr = 1'b1;
                    if (!mem_ready) begin
                        stall         = 1'b1;
                        state_next    = WAIT_WR;
                        wait_cnt_next = 8'd1;
                    end
                end
            end
            WAIT_RD, WAIT_WR: begin
                mem_rd = (state == WAIT_RD);
                mem_wr = (state == WAIT_WR);
                if (mem_ready) begin
                    if (state == WAIT_RD)
                        dbuf_next = mem_rdata;
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt == LIMIT) begin
                    if (state == WAIT_RD)
                        dbuf_next = 8'hFF;
                    err_next      = 1'b1;
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else begin
                    stall         = 1'b1;
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr    = (mem_rd | mem_wr) ? abuf : 16'h0000;
    assign mem_wdata   = mem_wr ? dbuf : 8'h00;
    assign data_out    = dbuf;
    assign data_out_en = data_buf_write;

endmodule

// File: tb/tb_bus_buffers.sv
// Randomized and directed bench for bus_buffers against a transaction-level model.
module tb_bus_buffers;

    localparam int WAIT_LIMIT = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr_in = '0;
    logic [7:0]  data_in = '0;
    logic        addr_buf_load = 0, addr_ff00_sel = 0, data_buf_load = 0, data_buf_write = 0;
    logic        addr_buf_write_ext = 0, data_buf_load_ext = 0, data_buf_write_ext = 0;
    logic [7:0]  data_out;
    logic        data_out_en;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 0;
    logic        stall, bus_error;

    bus_buffers #(.WAIT_LIMIT(WAIT_LIMIT), .HIGH_PAGE(8'hFF)) dut (
        .clock(clock), .reset(reset),
        .addr_in(addr_in), .data_in(data_in),
        .addr_buf_load(addr_buf_load), .addr_ff00_sel(addr_ff00_sel),
        .data_buf_load(data_buf_load), .data_buf_write(data_buf_write),
        .addr_buf_write_ext(addr_buf_write_ext), .data_buf_load_ext(data_buf_load_ext),
        .data_buf_write_ext(data_buf_write_ext),
        .data_out(data_out), .data_out_en(data_out_en),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int stall_seen = 0;
    int err_seen = 0;

    // Transaction-level model: buffers plus an in-flight transaction record
    logic [15:0] m_abuf;
    logic [7:0]  m_dbuf;
    bit          m_busy, m_is_read, m_err;
    int          m_waited;

    // Expectations for the current cycle, shared between sample and update
    bit          e_rd, e_wr, e_stall, e_timeout, e_conflict, e_cmd;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_abuf = '0; m_dbuf = '0; m_busy = 0; m_is_read = 0; m_err = 0; m_waited = 0;
    endtask

    task automatic applyStimulus(input bit abl, input bit sel, input logic [15:0] ain,
                                 input bit dbl, input logic [7:0] din, input bit dbw,
                                 input bit abwe, input bit dble, input bit dbwe,
                                 input bit rdy, input logic [7:0] rdata);
        addr_buf_load = abl; addr_ff00_sel = sel; addr_in = ain;
        data_buf_load = dbl; data_in = din; data_buf_write = dbw;
        addr_buf_write_ext = abwe; data_buf_load_ext = dble; data_buf_write_ext = dbwe;
        mem_ready = rdy; mem_rdata = rdata;
    endtask

    task automatic idleInputs();
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 0, 0, 0, 0, 8'h0);
    endtask

    // Sample on the falling edge, advance the model on the rising edge
    task automatic step();
        @(negedge clock);
        if (!m_busy) begin
            e_cmd      = addr_buf_write_ext && (data_buf_load_ext || data_buf_write_ext);
            e_rd       = addr_buf_write_ext && data_buf_load_ext;
            e_wr       = e_cmd && !e_rd;
            e_conflict = e_rd && data_buf_write_ext;
            e_timeout  = 0;
            e_stall    = e_cmd && !mem_ready;
        end else begin
            e_cmd      = 0;
            e_rd       = m_is_read;
            e_wr       = !m_is_read;
            e_conflict = 0;
            e_timeout  = !mem_ready && (m_waited == WAIT_LIMIT);
            e_stall    = !mem_ready && !e_timeout;
        end
        checkOutput("mem_rd", mem_rd, e_rd);
        checkOutput("mem_wr", mem_wr, e_wr);
        checkOutput("stall", stall, e_stall);
        checkOutput("mem_addr", mem_addr, (e_rd || e_wr) ? m_abuf : 16'h0);
        checkOutput("mem_wdata", mem_wdata, e_wr ? m_dbuf : 8'h0);
        checkOutput("data_out", data_out, m_dbuf);
        checkOutput("data_out_en", data_out_en, data_buf_write);
        checkOutput("bus_error", bus_error, m_err);
        if (stall) stall_seen++;
        if (bus_error) err_seen++;
        @(posedge clock);
        m_err = e_conflict || e_timeout;
        if (!m_busy) begin
            if (e_rd && mem_ready)      m_dbuf = mem_rdata;
            else if (data_buf_load)     m_dbuf = data_in;
            if (addr_buf_load)
                m_abuf = addr_ff00_sel ? {8'hFF, addr_in[7:0]} : addr_in;
            if (e_cmd && !mem_ready) begin
                m_busy = 1; m_is_read = e_rd; m_waited = 1;
            end
        end else if (mem_ready) begin
            if (m_is_read) m_dbuf = mem_rdata;
            m_busy = 0;
        end else if (e_timeout) begin
            if (m_is_read) m_dbuf = 8'hFF;
            m_busy = 0;
        end else begin
            m_waited++;
        end
        #1;
    endtask

    initial begin
        modelReset();
        #2;
        checkOutput("reset_mem_rd", mem_rd, 0);
        checkOutput("reset_mem_addr", mem_addr, 16'h0);
        checkOutput("reset_data_out", data_out, 8'h0);
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_bus_error", bus_error, 0);
        #10 reset = 1'b1;
        @(posedge clock); #1;

        // Zero-wait read
        applyStimulus(1, 0, 16'hC000, 0, 8'h0, 0, 0, 0, 0, 0, 8'h0); step();
        stall_seen = 0;
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1, 1, 1, 0, 1, 8'h3E); step();
        idleInputs(); step();
        checkOutput("zw_dbuf", data_out, 8'h3E);
        checkOutput("zw_stall_cycles", stall_seen, 0);

        // FF00 page write
        applyStimulus(1, 1, 16'h1244, 1, 8'h80, 0, 0, 0, 0, 0, 8'h0); step();
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 1, 0, 1, 1, 8'h0);
        @(negedge clock);
        checkOutput("ff00_addr", mem_addr, 16'hFF44);
        checkOutput("ff00_wdata", mem_wdata, 8'h80);
        @(posedge clock); #1;
        m_abuf = 16'hFF44;
        idleInputs(); step();

        // Wait states: ready low for three cycles then high
        applyStimulus(1, 0, 16'h0100, 0, 8'h0, 0, 0, 0, 0, 0, 8'h0); step();
        stall_seen = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 1, 1, 0, 0, 8'h00); step();
        end
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 1, 1, 0, 1, 8'hA5); step();
        idleInputs(); step();
        checkOutput("ws_stall_cycles", stall_seen, 3);
        checkOutput("ws_dbuf", data_out, 8'hA5);

        // Watchdog timeout
        stall_seen = 0; err_seen = 0;
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 1, 1, 0, 0, 8'h00); step();
        idleInputs();
        for (int i = 0; i < 19; i++) step();
        checkOutput("to_stall_cycles", stall_seen, 15);
        checkOutput("to_err_pulses", err_seen, 1);
        checkOutput("to_dbuf", data_out, 8'hFF);

        // Read/write conflict
        err_seen = 0;
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 1, 1, 1, 1, 8'h5A); step();
        idleInputs(); step(); step();
        checkOutput("cf_err_pulses", err_seen, 1);

        // Reset while a write is pending
        applyStimulus(1, 0, 16'h2345, 1, 8'h77, 0, 0, 0, 0, 0, 8'h0); step();
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 1, 0, 1, 0, 8'h0); step();
        idleInputs(); step();
        #1;
        checkOutput("rst_pre_mem_wr", mem_wr, 1);
        reset = 1'b0;
        #1;
        checkOutput("rst_mem_wr", mem_wr, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0);
        modelReset();
        @(posedge clock); #2;
        reset = 1'b1;
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0, 1, 1, 0, 1, 8'h00); step();
        idleInputs(); step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 16'($urandom),
                          $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 8'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
